// File: rtl/weight_loader_param.sv
// Sequential weight loader: streams TOTAL_WEIGHTS words from memory into a shadow buffer, then publishes them atomically.
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN adds a 16-bit checksum output of the published weights.
module weight_loader_param #(
  parameter int IN_SIZE    = 3,
  parameter int OUT_SIZE   = 2,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int RD_LATENCY = 1,
  localparam int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  output logic                       mem_en,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic [W-1:0]               mem_rdata,
  output logic [TOTAL_WEIGHTS*W-1:0] data_out,
  output logic                       busy,
  output logic                       done
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                checksum
`endif
);

  localparam int CW = $clog2(TOTAL_WEIGHTS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       issue_cnt, recv_cnt;
  logic [RD_LATENCY-1:0] valid_pipe;
  logic [W-1:0]        shadow [TOTAL_WEIGHTS];
  logic                last_issue, load_out;

  assign last_issue = (issue_cnt == CW'(TOTAL_WEIGHTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The output register is loaded on the edge that enters DONE, so the new vector is visible together with done.
  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    load_out   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = FETCH;
      end
      FETCH: begin
        mem_en = 1'b1;
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (recv_cnt == CW'(TOTAL_WEIGHTS)) begin
          state_next = DONE;
          load_out   = 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      valid_pipe <= '0;
      mem_addr   <= '0;
      data_out   <= '0;
      for (int k = 0; k < TOTAL_WEIGHTS; k++) shadow[k] <= '0;
    end else begin
      valid_pipe <= (valid_pipe << 1) | RD_LATENCY'(mem_en);
      if (state == IDLE && start) begin
        mem_addr  <= base_addr;
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end
      // Address stops on the last issued word so it holds that value outside FETCH.
      if (mem_en) begin
        issue_cnt <= issue_cnt + CW'(1);
        if (!last_issue) mem_addr <= mem_addr + ADDR_WIDTH'(1);
      end
      if (valid_pipe[RD_LATENCY-1]) begin
        for (int k = 0; k < TOTAL_WEIGHTS; k++)
          if (recv_cnt == CW'(k)) shadow[k] <= mem_rdata;
        recv_cnt <= recv_cnt + CW'(1);
      end
      if (load_out)
        for (int k = 0; k < TOTAL_WEIGHTS; k++) data_out[k*W +: W] <= shadow[k];
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] shadow_sum;

  always_comb begin
    shadow_sum = '0;
    for (int k = 0; k < TOTAL_WEIGHTS; k++) shadow_sum = shadow_sum + 16'(shadow[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        checksum <= '0;
    else if (load_out) checksum <= shadow_sum;
  end
`endif

endmodule
